edge_event_arbiter: RTL and testbench

Watches N synchronous single-bit lanes, detects a 0->1 transition on each, and holds one pending event per lane. Pending events are sequenced one at a time to a single consumer over a valid/ready interface with round-robin fairness. Sticky per-lane overflow flags record events lost because the lane already had one pending. It sits between the raw status/strobe lines and the shared event-handling logic, so that logic can service edges from many sources.

---
 rtl/edge_event_arbiter.sv | 121 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: one pending event per lane, sticky overflow on loss,
// round-robin sequencing of pending lanes to a single valid/ready consumer.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    din,
    input  logic [N-1:0]    lane_en,
    output logic            evt_valid,
    output logic [IDXW-1:0] evt_idx,
    input  logic            evt_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic            ovf_clr
);

    // state | meaning
    // IDLE  | no offer outstanding; grant the next pending lane after rr_ptr
    // OFFER | evt_valid high, evt_idx frozen until the consumer accepts
    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    din_q;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    overflow_q, overflow_d;
    logic            evt_valid_q, evt_valid_d;
    logic [IDXW-1:0] evt_idx_q, evt_idx_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    acc_vec;
    logic [N-1:0]    ovf_set;
    logic            accept;

    function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] req,
                                                input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] pick;
        logic [IDXW-1:0] jj;
        logic            found;
        int              j;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(ptr) + k) % N;
            jj = IDXW'(j);
            if (!found && req[jj]) begin
                pick  = jj;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign rise   = din & ~din_q & lane_en;
    assign accept = evt_valid_q & evt_ready;

    always_comb begin
        acc_vec = '0;
        if (accept) acc_vec[evt_idx_q] = 1'b1;
    end

    // A rise in the accept cycle re-arms the lane instead of counting as a loss.
    assign ovf_set    = rise & pending_q & ~acc_vec;
    assign pending_d  = (pending_q & ~acc_vec) | rise;
    assign overflow_d = ovf_clr ? ovf_set : (overflow_q | ovf_set);

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    evt_idx_d   = rr_pick(pending_q, rr_ptr_q);
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = evt_idx_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            din_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            rr_ptr_q    <= IDXW'(N - 1);
        end else begin
            state_q     <= state_d;
            din_q       <= din;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4): edge detect, round-robin order,
// overflow/clear priority, rise-during-accept, stall stability and async reset.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    din;
    logic [N-1:0]    lane_en;
    logic            evt_valid;
    logic [IDXW-1:0] evt_idx;
    logic            evt_ready;
    logic [N-1:0]    pending;
    logic [N-1:0]    overflow;
    logic            ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    edge_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .lane_en   (lane_en),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled 2 time units after each rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din       = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        din       = 4'hF;
        lane_en   = 4'hF;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // reset values, lanes held high through release
        step();
        chk("rst_valid",    32'(evt_valid), 0);
        chk("rst_idx",      32'(evt_idx),   0);
        chk("rst_pending",  32'(pending),   0);
        chk("rst_overflow", 32'(overflow),  0);
        reset = 1'b0;
        step();
        chk("rel_pending", 32'(pending),   32'hF);
        chk("rel_valid0",  32'(evt_valid), 0);
        step();
        chk("rel_valid1",  32'(evt_valid), 1);
        chk("rel_idx0",    32'(evt_idx),   0);
        // asynchronous reset mid-offer, observed without a clock edge
        reset = 1'b1;
        #1;
        chk("arst_valid",    32'(evt_valid), 0);
        chk("arst_pending",  32'(pending),   0);
        chk("arst_overflow", 32'(overflow),  0);
        din = '0;
        step();
        reset = 1'b0;
        step();

        // single edge on lane 2, held high
        din = 4'b0100;
        step();
        chk("se_pending", 32'(pending),   32'h4);
        chk("se_valid0",  32'(evt_valid), 0);
        step();
        chk("se_valid1",  32'(evt_valid), 1);
        chk("se_idx",     32'(evt_idx),   2);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("se_acc_valid",   32'(evt_valid), 0);
        chk("se_acc_pending", 32'(pending),   0);
        step(); step(); step();
        chk("se_hold_valid",   32'(evt_valid), 0);
        chk("se_hold_pending", 32'(pending),   0);

        // round-robin from reset pointer: 0,1,3 two cycles apart
        do_reset();
        din       = 4'b1011;
        evt_ready = 1'b1;
        step();
        chk("rr_pending", 32'(pending), 32'hB);
        step();
        chk("rr_g0_valid", 32'(evt_valid), 1);
        chk("rr_g0_idx",   32'(evt_idx),   0);
        step();
        chk("rr_bubble0", 32'(evt_valid), 0);
        step();
        chk("rr_g1_valid", 32'(evt_valid), 1);
        chk("rr_g1_idx",   32'(evt_idx),   1);
        step();
        chk("rr_bubble1", 32'(evt_valid), 0);
        step();
        chk("rr_g3_valid", 32'(evt_valid), 1);
        chk("rr_g3_idx",   32'(evt_idx),   3);
        step();
        chk("rr_done_pending", 32'(pending), 0);

        // after granting lane 1, lanes 0 and 3 together: 3 wins
        do_reset();
        din       = 4'b0010;
        evt_ready = 1'b1;
        step(); step();
        chk("rr2_g1_idx", 32'(evt_idx), 1);
        step();
        din = 4'b1001;
        step();
        chk("rr2_pending", 32'(pending), 32'h9);
        step();
        chk("rr2_first_valid", 32'(evt_valid), 1);
        chk("rr2_first_idx",   32'(evt_idx),   3);
        step(); step();
        chk("rr2_second_idx",  32'(evt_idx),   0);
        step();
        evt_ready = 1'b0;
        din       = 4'b0000;
        step();

        // overflow: lane 1 pulsed twice while stalled
        din = 4'b0010; step();
        din = 4'b0000; step();
        din = 4'b0010; step();
        chk("ovf_bits",    32'(overflow),  32'h2);
        chk("ovf_pending", 32'(pending),   32'h2);
        chk("ovf_idx",     32'(evt_idx),   1);
        evt_ready = 1'b1;
        step();
        chk("ovf_acc_valid",   32'(evt_valid), 0);
        chk("ovf_acc_pending", 32'(pending),   0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ovf_single_event", 32'(evt_valid), 0);
        end
        evt_ready = 1'b0;
        ovf_clr   = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // new overflow in the same cycle as ovf_clr survives
        din = 4'b0000; step();
        din = 4'b0010; step();
        din = 4'b0000; step();
        chk("ovf2_valid", 32'(evt_valid), 1);
        din     = 4'b0010;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", 32'(overflow), 32'h2);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        ovf_clr   = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 0);

        // rise on lane 2 during its own accept
        din = 4'b0000; step();
        din = 4'b0100; step();
        din = 4'b0000; step();
        chk("rda_valid", 32'(evt_valid), 1);
        chk("rda_idx",   32'(evt_idx),   2);
        din       = 4'b0100;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("rda_pending",  32'(pending),   32'h4);
        chk("rda_overflow", 32'(overflow),  0);
        chk("rda_bubble",   32'(evt_valid), 0);
        step();
        chk("rda_reoffer_valid", 32'(evt_valid), 1);
        chk("rda_reoffer_idx",   32'(evt_idx),   2);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("rda_done_pending", 32'(pending), 0);

        // stall: offer on lane 0 stays put while others rise and lane_en drops
        din = 4'b0000; step();
        din = 4'b0001; step();
        step();
        chk("st_valid0", 32'(evt_valid), 1);
        chk("st_idx0",   32'(evt_idx),   0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) din = 4'b1011;
            if (i == 4) lane_en = 4'b1110;
            step();
            chk("st_valid", 32'(evt_valid), 1);
            chk("st_idx",   32'(evt_idx),   0);
        end
        chk("st_pending", 32'(pending), 32'hB);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        lane_en   = 4'hF;
        chk("st_acc_valid",   32'(evt_valid), 0);
        chk("st_acc_pending", 32'(pending),   32'hA);
        step();
        chk("st_next_idx", 32'(evt_idx), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
